// File: rtl/sipo_frame_rx.sv
//------------------------------------------------------------------------------
// sipo_frame_rx : LSB-first serial frame receiver (start/data/parity/stop)
//                 with a one-word valid/ready holding register.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sipo_frame_rx #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic [7:0]       frame_count
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             par_bit;

  logic             last_bit;
  logic             stop_eval;
  logic             bad_par;
  logic             good;
  logic             load;
  logic             drop;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last_bit  = (cnt == CW'(WIDTH - 1));
    if (bit_en) begin
      case (state)
        IDLE:    if (serial_in) state_nxt = DATA;
        DATA:    if (last_bit)  state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Frame verdict in STOP: stop-bit error outranks parity error.
  always_comb begin
    stop_eval = bit_en && (state == STOP);
    bad_par   = (PARITY_EN != 0) && ((^shreg) != par_bit);
    good      = stop_eval && !serial_in && !bad_par;
    load      = good && (!data_valid || data_ready);
    drop      = good && data_valid && !data_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      cnt         <= '0;
      par_bit     <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_count <= 8'd0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      parity_err <= stop_eval && !serial_in && bad_par;
      frame_err  <= stop_eval && serial_in;
      overrun    <= drop;

      if (bit_en) begin
        case (state)
          IDLE:   if (serial_in) cnt <= '0;
          DATA: begin
            shreg <= {serial_in, shreg[WIDTH-1:1]};
            cnt   <= cnt + 1'b1;
          end
          PARITY: par_bit <= serial_in;
          default: ;
        endcase
      end

      if (load) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
        if (frame_count != 8'hFF) frame_count <= frame_count + 8'd1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
